// File: rtl/core_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Contents:
//   DEFAULT_BOOT_ADDR  first fetch address after reset (word aligned)
//   NOP_INSTR          value presented on the slot instruction when it is empty
//   *_ENC              state encodings used by fetch_state_e
//   align_target()     forces a redirect target onto a word boundary
package core_fetch_ctrl_pkg;

    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;

    localparam logic [1:0] S_IDLE_ENC = 2'd0;
    localparam logic [1:0] S_REQ_ENC  = 2'd1;
    localparam logic [1:0] S_WAIT_ENC = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = S_IDLE_ENC,
        S_REQ  = S_REQ_ENC,
        S_WAIT = S_WAIT_ENC
    } fetch_state_e;

    // Bits [1:0] of a redirect target are dropped; bit 1 is reported
    // separately as a misalignment, bit 0 is ignored.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/core_fetch_ctrl_if.sv
// Instruction-bus port bundle between the fetch sequencer and the memory side.
// Signals:
//   o_ibus_req     fetch request (driven by the fetch side)
//   o_ibus_addr    word-aligned fetch address
//   i_ibus_gnt     request accepted this cycle
//   i_ibus_rvalid  response valid, at least one cycle after the grant
//   i_ibus_rdata   instruction word
//
// Handshake: a request transfers on a cycle where o_ibus_req && i_ibus_gnt
// (req acts as valid, gnt as ready); gnt without req carries no meaning.
// Exactly one response (i_ibus_rvalid for one cycle) follows each transfer,
// and at most one transfer is outstanding at any time.
interface core_fetch_ctrl_if;

    logic        o_ibus_req;
    logic [31:0] o_ibus_addr;
    logic        i_ibus_gnt;
    logic        i_ibus_rvalid;
    logic [31:0] i_ibus_rdata;

    modport master (
        output o_ibus_req,
        output o_ibus_addr,
        input  i_ibus_gnt,
        input  i_ibus_rvalid,
        input  i_ibus_rdata
    );

    modport slave (
        input  o_ibus_req,
        input  o_ibus_addr,
        output i_ibus_gnt,
        output i_ibus_rvalid,
        output i_ibus_rdata
    );

endinterface

// File: rtl/core_fetch_slot.sv
// Single-entry holding register for the fetched instruction handed to decode.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load/load_pc/load_instr  fill the slot with a new instruction
//   consume             decode took the instruction this cycle
//   clear               redirect: drop whatever the slot holds
//   valid, pc, instr    slot contents (instr reads NOP_INSTR when empty)
// Priority is clear > load > consume, so a load in the same cycle as a
// consume refills the slot without a bubble.
module core_fetch_slot
    import core_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_BOOT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    input  logic        consume,
    input  logic        clear,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (consume) begin
            // PC is kept; only the instruction reverts to a NOP
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/core_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the instruction-bus
// request/grant/response handshake, holds one instruction for decode and
// applies EX (branch/JALR) and ID (JAL) redirects.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ibus                  instruction-bus bundle (master side)
//   o_if_valid/pc/instr   instruction slot presented to decode
//   i_id_ready            decode consumes the slot when valid & ready
//   i_id_jal(_target)     decode-stage JAL redirect
//   i_ex_redirect/target  execute-stage redirect (wins over JAL)
//   o_flush_ex            one-cycle pulse after an EX redirect
//   o_misalign            one-cycle pulse when an accepted target had bit 1 set
//   o_dbg_state           current FSM state
module core_fetch_ctrl
    import core_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    core_fetch_ctrl_if.master   ibus,
    output logic                o_if_valid,
    output logic [31:0]         o_if_pc,
    output logic [31:0]         o_if_instr,
    input  logic                i_id_ready,
    input  logic                i_id_jal,
    input  logic [31:0]         i_id_jal_target,
    input  logic                i_ex_redirect,
    input  logic [31:0]         i_ex_target,
    output logic                o_flush_ex,
    output logic                o_misalign,
    output fetch_state_e        o_dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;

    logic         redirect;
    logic [31:0]  raw_target;
    logic         consume;
    logic         req;
    logic         gnt_acc;
    logic         rsp;
    logic         load;

    // A JAL that coincides with an EX redirect is on the wrong path.
    assign redirect   = i_ex_redirect | i_id_jal;
    assign raw_target = i_ex_redirect ? i_ex_target : i_id_jal_target;

    // Decode's ready is ignored on a redirect cycle: the slot is being cleared.
    assign consume = o_if_valid & i_id_ready & ~redirect;
    assign req     = (state_q == S_REQ) & (~o_if_valid | consume);
    assign gnt_acc = req & ibus.i_ibus_gnt;
    assign rsp     = (state_q == S_WAIT) & ibus.i_ibus_rvalid;
    assign load    = rsp & ~discard_q & ~redirect;

    assign ibus.o_ibus_req  = req;
    assign ibus.o_ibus_addr = pc_q;
    assign o_dbg_state      = state_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (gnt_acc) begin
                    state_d = S_WAIT;
                    // The granted fetch is already stale
                    if (redirect) discard_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (ibus.i_ibus_rvalid) begin
                    // A response arriving together with a redirect is simply
                    // dropped; nothing remains outstanding, so no discard.
                    state_d   = S_REQ;
                    discard_d = 1'b0;
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            pc_d = align_target(raw_target);
        end else if (load) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= BOOT_ADDR;
            discard_q  <= 1'b0;
            o_flush_ex <= 1'b0;
            o_misalign <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            o_flush_ex <= i_ex_redirect;
            o_misalign <= redirect & raw_target[1];
        end
    end

    core_fetch_slot #(
        .RESET_PC (BOOT_ADDR)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_pc    (pc_q),
        .load_instr (ibus.i_ibus_rdata),
        .consume    (consume),
        .clear      (redirect),
        .valid      (o_if_valid),
        .pc         (o_if_pc),
        .instr      (o_if_instr)
    );

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Directed bench for core_fetch_ctrl: per-cycle vector table of bus/decode
// inputs with hand-computed outputs, a queue of PCs decode must receive, and
// hand-written reset sequences.
module tb_core_fetch_ctrl;
    import core_fetch_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    core_fetch_ctrl_if bus ();

    logic         id_ready, id_jal, ex_redirect;
    logic [31:0]  id_jal_target, ex_target;
    logic         if_valid, flush_ex, misalign;
    logic [31:0]  if_pc, if_instr;
    fetch_state_e dbg_state;

    core_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ibus            (bus),
        .o_if_valid      (if_valid),
        .o_if_pc         (if_pc),
        .o_if_instr      (if_instr),
        .i_id_ready      (id_ready),
        .i_id_jal        (id_jal),
        .i_id_jal_target (id_jal_target),
        .i_ex_redirect   (ex_redirect),
        .i_ex_target     (ex_target),
        .o_flush_ex      (flush_ex),
        .o_misalign      (misalign),
        .o_dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        jal;
        logic [31:0] jtgt;
        logic        ex;
        logic [31:0] etgt;
        logic        req;
        logic [31:0] addr;
        logic        val;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fl;
        logic        mi;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic rdy, input logic jal, input logic [31:0] jtgt,
                       input logic ex, input logic [31:0] etgt,
                       input logic req, input logic [31:0] addr, input logic val,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic mi);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.jal = jal;
        v.jtgt = jtgt; v.ex = ex; v.etgt = etgt; v.req = req; v.addr = addr;
        v.val = val; v.pc = pc; v.instr = instr; v.fl = fl; v.mi = mi;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus.i_ibus_gnt    = 1'b0;
        bus.i_ibus_rvalid = 1'b0;
        bus.i_ibus_rdata  = 32'h0;
        id_ready          = 1'b1;
        id_jal            = 1'b0;
        id_jal_target     = 32'h0;
        ex_redirect       = 1'b0;
        ex_target         = 32'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},   {31'b0, bus.o_ibus_req}, 32'h0);
        chk({tag, " addr"},  bus.o_ibus_addr, 32'h0);
        chk({tag, " valid"}, {31'b0, if_valid}, 32'h0);
        chk({tag, " pc"},    if_pc, 32'h0);
        chk({tag, " instr"}, if_instr, NOP_INSTR);
        chk({tag, " flush"}, {31'b0, flush_ex}, 32'h0);
        chk({tag, " misal"}, {31'b0, misalign}, 32'h0);
        chk({tag, " state"}, {30'b0, dbg_state}, {30'b0, S_IDLE});
    endtask

    localparam logic [31:0] I0 = 32'h0010_0093;
    localparam logic [31:0] I1 = 32'h0020_0113;
    localparam logic [31:0] I2 = 32'hDEAD_0001;
    localparam logic [31:0] I3 = 32'h0030_0193;
    localparam logic [31:0] I4 = 32'h0040_0213;
    localparam logic [31:0] I5 = 32'h0050_0293;
    localparam logic [31:0] I6 = 32'hDEAD_0002;
    localparam logic [31:0] I7 = 32'h0070_0393;
    localparam logic [31:0] NOP = NOP_INSTR;

    initial begin
        drive_idle();

        // ---- reset state ----
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");

        // ----      gnt rv rdata rdy jal jtgt         ex etgt         req addr         val pc           instr fl mi
        // sequential fetch, zero-wait bus
        add(0, 0, 0,  1, 0, 0,            0, 0,            0, 32'h0,        0, 32'h0,        NOP, 0, 0); // v0  IDLE
        add(1, 0, 0,  1, 0, 0,            0, 0,            1, 32'h0,        0, 32'h0,        NOP, 0, 0); // v1  REQ 0x0
        add(0, 1, I0, 1, 0, 0,            0, 0,            0, 32'h0,        0, 32'h0,        NOP, 0, 0); // v2  rsp
        add(1, 0, 0,  1, 0, 0,            0, 0,            1, 32'h4,        1, 32'h0,        I0,  0, 0); // v3  REQ 0x4, slot 0x0
        add(0, 1, I1, 1, 0, 0,            0, 0,            0, 32'h4,        0, 32'h0,        NOP, 0, 0); // v4
        add(1, 0, 0,  1, 0, 0,            0, 0,            1, 32'h8,        1, 32'h4,        I1,  0, 0); // v5  REQ 0x8
        // EX redirect while waiting on 0x8
        add(0, 0, 0,  1, 0, 0,            1, 32'h100,      0, 32'h8,        0, 32'h4,        NOP, 0, 0); // v6
        add(0, 1, I2, 1, 0, 0,            0, 0,            0, 32'h100,      0, 32'h4,        NOP, 1, 0); // v7  stale rsp dropped
        add(0, 0, 0,  1, 0, 0,            0, 0,            1, 32'h100,      0, 32'h4,        NOP, 0, 0); // v8  no gnt
        add(1, 0, 0,  1, 0, 0,            0, 0,            1, 32'h100,      0, 32'h4,        NOP, 0, 0); // v9
        add(0, 1, I3, 1, 0, 0,            0, 0,            0, 32'h100,      0, 32'h4,        NOP, 0, 0); // v10
        // decode stalls for 5 cycles: no request, gnt ignored
        for (int k = 0; k < 5; k++)
            add(1, 0, 0, 0, 0, 0,         0, 0,            0, 32'h104,      1, 32'h100,      I3,  0, 0); // v11-v15
        add(0, 0, 0,  1, 0, 0,            0, 0,            1, 32'h104,      1, 32'h100,      I3,  0, 0); // v16 consumed
        // EX and JAL together: EX wins
        add(0, 0, 0,  1, 1, 32'h300,      1, 32'h200,      1, 32'h104,      0, 32'h100,      NOP, 0, 0); // v17
        add(1, 0, 0,  1, 0, 0,            0, 0,            1, 32'h200,      0, 32'h100,      NOP, 1, 0); // v18
        add(0, 1, I4, 1, 0, 0,            0, 0,            0, 32'h200,      0, 32'h100,      NOP, 0, 0); // v19
        // misaligned EX target clears a full slot, ready ignored
        add(1, 0, 0,  1, 0, 0,            1, 32'h106,      0, 32'h204,      1, 32'h200,      I4,  0, 0); // v20
        add(1, 0, 0,  1, 0, 0,            0, 0,            1, 32'h104,      0, 32'h200,      NOP, 1, 1); // v21
        add(0, 1, I5, 1, 0, 0,            0, 0,            0, 32'h104,      0, 32'h200,      NOP, 0, 0); // v22
        // JAL with a full slot, then JAL coinciding with a grant
        add(0, 0, 0,  1, 1, 32'h300,      0, 0,            0, 32'h108,      1, 32'h104,      I5,  0, 0); // v23
        add(1, 0, 0,  1, 1, 32'h502,      0, 0,            1, 32'h300,      0, 32'h104,      NOP, 0, 0); // v24
        // redirect while discard pending: retarget only
        add(0, 0, 0,  1, 0, 0,            1, 32'hFFFF_FFFD, 0, 32'h500,     0, 32'h104,      NOP, 0, 1); // v25
        add(0, 1, I6, 1, 0, 0,            0, 0,            0, 32'hFFFF_FFFC, 0, 32'h104,     NOP, 1, 0); // v26
        add(1, 0, 0,  1, 0, 0,            0, 0,            1, 32'hFFFF_FFFC, 0, 32'h104,     NOP, 0, 0); // v27
        add(0, 1, I7, 1, 0, 0,            0, 0,            0, 32'hFFFF_FFFC, 0, 32'h104,     NOP, 0, 0); // v28
        // PC wraps to zero
        add(0, 0, 0,  1, 0, 0,            0, 0,            1, 32'h0,        1, 32'hFFFF_FFFC, I7, 0, 0); // v29
        add(1, 0, 0,  1, 0, 0,            0, 0,            1, 32'h0,        0, 32'hFFFF_FFFC, NOP, 0, 0); // v30 -> WAIT

        // PCs decode must receive, in order
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'hFFFF_FFFC);

        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            bus.i_ibus_gnt    = v.gnt;
            bus.i_ibus_rvalid = v.rv;
            bus.i_ibus_rdata  = v.rdata;
            id_ready          = v.rdy;
            id_jal            = v.jal;
            id_jal_target     = v.jtgt;
            ex_redirect       = v.ex;
            ex_target         = v.etgt;
            #1;
            chk($sformatf("v%0d req", i),   {31'b0, bus.o_ibus_req}, {31'b0, v.req});
            chk($sformatf("v%0d addr", i),  bus.o_ibus_addr, v.addr);
            chk($sformatf("v%0d valid", i), {31'b0, if_valid}, {31'b0, v.val});
            chk($sformatf("v%0d pc", i),    if_pc, v.pc);
            chk($sformatf("v%0d instr", i), if_instr, v.instr);
            chk($sformatf("v%0d flush", i), {31'b0, flush_ex}, {31'b0, v.fl});
            chk($sformatf("v%0d misal", i), {31'b0, misalign}, {31'b0, v.mi});
            if (if_valid && v.rdy && !v.ex && !v.jal) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL v%0d consume: got pc %h expected no consumption", i, if_pc);
                end else begin
                    chk($sformatf("v%0d consume pc", i), if_pc, exp_q.pop_front());
                end
            end
            @(posedge clk);
            @(negedge clk);
        end

        // ---- asynchronous reset while waiting on a response ----
        drive_idle();
        chk("pre-reset state", {30'b0, dbg_state}, {30'b0, S_WAIT});
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("reset held");

        // ---- first request lands in the 2nd cycle after release ----
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release c1 req", {31'b0, bus.o_ibus_req}, 32'h0);
        @(posedge clk);
        #1;
        chk("release c2 req",  {31'b0, bus.o_ibus_req}, 32'h1);
        chk("release c2 addr", bus.o_ibus_addr, 32'h0);

        chk("consume queue left", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
